// File: rtl/traffic_button_ctrl.sv
// traffic_button_ctrl: single-intersection main-road light controller with a
// pedestrian request button. Main road cycles GREEN -> YELLOW -> RED on fixed
// timers; an accepted button press during GREEN cuts green short, and a
// cooldown window after any accepted press ignores further presses.
`timescale 1ns/1ps

module traffic_button_ctrl #(
  parameter int unsigned GREEN_TIME  = 25,
  parameter int unsigned YELLOW_TIME = 5,
  parameter int unsigned RED_TIME    = 10,
  parameter int unsigned COOLDOWN    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_btn,
  output logic [1:0] main_light,
  output logic       ped_light
);

  // Counters are sized for the largest duration so one width serves all.
  localparam int unsigned MAX_GY  = (GREEN_TIME > YELLOW_TIME) ? GREEN_TIME : YELLOW_TIME;
  localparam int unsigned MAX_RC  = (RED_TIME > COOLDOWN) ? RED_TIME : COOLDOWN;
  localparam int unsigned MAX_ALL = (MAX_GY > MAX_RC) ? MAX_GY : MAX_RC;
  localparam int unsigned CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_TIME - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TIME - 1);
  localparam logic [CW-1:0] RED_LAST    = CW'(RED_TIME - 1);
  localparam logic [CW-1:0] CD_LOAD     = CW'(COOLDOWN);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] r_timer;
  logic [CW-1:0] r_cooldown;
  logic          r_btn_d;

  logic w_press;
  logic w_accept;

  // A held button produces a single press; presses only count outside cooldown.
  assign w_press  = ped_btn & ~r_btn_d;
  assign w_accept = w_press & (r_cooldown == '0);

  // Button delay register for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_btn_d <= 1'b0;
    else        r_btn_d <= ped_btn;
  end

  // Cooldown: load on an accepted press, then count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cooldown <= '0;
    end else if (w_accept) begin
      r_cooldown <= CD_LOAD;
    end else if (r_cooldown != '0) begin
      r_cooldown <= r_cooldown - 1'b1;
    end
  end

  // Phase FSM with its phase timer; timer clears on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= GREEN;
      r_timer <= '0;
    end else begin
      case (state)
        GREEN: begin
          if (w_accept || (r_timer == GREEN_LAST)) begin
            state   <= YELLOW;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        YELLOW: begin
          if (r_timer == YELLOW_LAST) begin
            state   <= RED;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RED: begin
          if (r_timer == RED_LAST) begin
            state   <= GREEN;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          // Unused encoding 3 falls back to a clean GREEN phase.
          state   <= GREEN;
          r_timer <= '0;
        end
      endcase
    end
  end

  // Lamp decode from the current state.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    main_light = 2'b01;
    ped_light  = 1'b0;
    case (state)
      GREEN:   main_light = 2'b01;
      YELLOW:  main_light = 2'b10;
      RED: begin
        main_light = 2'b00;
        ped_light  = 1'b1;
      end
      default: main_light = 2'b01;
    endcase
  end

endmodule

// File: tb/tb_traffic_button_ctrl.sv
// Directed testbench for traffic_button_ctrl: walks an absolute timeline of
// button presses and resets, checking lamps and the cooldown counter against
// hand-computed values.
`timescale 1ns/1ps

module tb_traffic_button_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ped_btn;
  logic [1:0] main_light;
  logic       ped_light;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_YELLOW = 2'b10;
  localparam logic [1:0] L_RED    = 2'b00;

  traffic_button_ctrl #(
    .GREEN_TIME (25),
    .YELLOW_TIME(5),
    .RED_TIME   (10),
    .COOLDOWN   (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ped_btn   (ped_btn),
    .main_light(main_light),
    .ped_light (ped_light)
  );

  // Rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic at(input longint unsigned t);
    if (t > $time) #(t - $time);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_lamps(input string tag, input logic [1:0] exp_main, input logic exp_ped);
    check({tag, "_main"}, {6'd0, main_light}, {6'd0, exp_main});
    check({tag, "_ped"},  {7'd0, ped_light},  {7'd0, exp_ped});
  endtask

  initial begin
    rst_n   = 1'b0;
    ped_btn = 1'b0;

    // Reset and a full uninterrupted cycle.
    at(2);    check_lamps("reset", L_GREEN, 1'b0);
    check("reset_cooldown", {3'd0, dut.r_cooldown}, 8'd0);
    at(10);   rst_n = 1'b1;
    at(250);  check_lamps("green_last", L_GREEN, 1'b0);
    at(260);  check_lamps("yellow_first", L_YELLOW, 1'b0);
    at(300);  check_lamps("yellow_last", L_YELLOW, 1'b0);
    at(310);  check_lamps("red_first", L_RED, 1'b1);

    // Press in RED: no phase change, cooldown loaded at 355 ns.
    at(350);  ped_btn = 1'b1;
    at(360);  ped_btn = 1'b0;
    check("red_press_cd", {3'd0, dut.r_cooldown}, 8'd20);
    at(400);  check_lamps("red_last", L_RED, 1'b1);
    at(410);  check_lamps("green_again", L_GREEN, 1'b0);
    at(550);  check("cd_one", {3'd0, dut.r_cooldown}, 8'd1);
    at(560);  check("cd_zero", {3'd0, dut.r_cooldown}, 8'd0);

    // Press in GREEN with cooldown expired: early yellow at 635 ns.
    at(630);  check_lamps("pre_press_green", L_GREEN, 1'b0);
    ped_btn = 1'b1;
    at(640);  ped_btn = 1'b0;
    check_lamps("early_yellow", L_YELLOW, 1'b0);
    at(680);  check_lamps("early_yellow_last", L_YELLOW, 1'b0);
    at(690);  check_lamps("red_after_early", L_RED, 1'b1);
    at(780);  check_lamps("red_after_early_last", L_RED, 1'b1);
    at(790);  check_lamps("green_785", L_GREEN, 1'b0);

    // Press during cooldown: ignored, counter not reloaded.
    ped_btn = 1'b1;
    at(800);  ped_btn = 1'b0;
    check_lamps("ignored_press", L_GREEN, 1'b0);
    check("cd_not_reloaded", {3'd0, dut.r_cooldown}, 8'd4);
    at(950);  check_lamps("still_green", L_GREEN, 1'b0);

    // Re-press after cooldown: yellow at 955 ns.
    ped_btn = 1'b1;
    at(960);  ped_btn = 1'b0;
    check_lamps("repress_yellow", L_YELLOW, 1'b0);
    at(1010); check_lamps("repress_red", L_RED, 1'b1);
    at(1110); check_lamps("repress_green", L_GREEN, 1'b0);

    // Held button for 40 cycles: one early yellow only.
    at(1160); ped_btn = 1'b1;
    at(1170); check_lamps("held_yellow", L_YELLOW, 1'b0);
    at(1220); check_lamps("held_red", L_RED, 1'b1);
    at(1320); check_lamps("held_green", L_GREEN, 1'b0);
    at(1400); check_lamps("held_no_retrigger_a", L_GREEN, 1'b0);
    at(1500); check_lamps("held_no_retrigger_b", L_GREEN, 1'b0);
    at(1560); check_lamps("held_no_retrigger_c", L_GREEN, 1'b0);
    ped_btn = 1'b0;
    at(1570); check_lamps("natural_yellow", L_YELLOW, 1'b0);

    // Press in YELLOW loads cooldown without a phase change.
    ped_btn = 1'b1;
    at(1580); ped_btn = 1'b0;
    check_lamps("yellow_press", L_YELLOW, 1'b0);
    check("yellow_press_cd", {3'd0, dut.r_cooldown}, 8'd20);

    // Reset mid-yellow: immediate GREEN, counters cleared.
    at(1590); rst_n = 1'b0;
    at(1591); check_lamps("mid_reset", L_GREEN, 1'b0);
    check("mid_reset_cd", {3'd0, dut.r_cooldown}, 8'd0);
    check("mid_reset_timer", {3'd0, dut.r_timer}, 8'd0);
    at(1600); rst_n = 1'b1;

    // Cleared cooldown lets a fresh press through right away.
    at(1650); check_lamps("post_reset_green", L_GREEN, 1'b0);
    ped_btn = 1'b1;
    at(1660); ped_btn = 1'b0;
    check_lamps("post_reset_yellow", L_YELLOW, 1'b0);
    at(1710); check_lamps("post_reset_red", L_RED, 1'b1);
    at(1810); check_lamps("post_reset_green2", L_GREEN, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
